fma_byte_serial_acc: RTL and testbench



---
 rtl/fma_byte_serial_acc.sv | 156 +++++++++++++++
 tb/tb_fma_byte_serial_acc.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fma_byte_serial_acc.sv
`default_nettype none
// ============================================================================
// Module   : fma_byte_serial_acc (with ksa_8 adder slice)
// Purpose  : Byte-serial accumulation of multiplier products through a single
//            8-bit Kogge-Stone slice with a registered inter-byte carry.
//            Optional macro FMA_ACC_SAT_EN: unsigned saturation on overflow.
// Revision : 1.0 - initial release
// ============================================================================

module ksa_8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cy
);

    logic [7:0] p;
    logic [7:0] g_lvl [0:3];
    logic [7:0] p_lvl [0:2];

    assign p = a ^ b;
    // Carry-in folded into bit 0 so every prefix group ends at the true carry.
    assign g_lvl[0] = (a & b) | {7'b0, p[0] & cin};
    assign p_lvl[0] = p;

    generate
        for (genvar k = 0; k < 3; k++) begin : g_level
            localparam int DIST = 1 << k;
            assign g_lvl[k+1] = g_lvl[k] | (p_lvl[k] & (g_lvl[k] << DIST));
            if (k < 2) begin : g_prop
                assign p_lvl[k+1] = p_lvl[k] & (p_lvl[k] << DIST);
            end
        end
    endgenerate

    assign sum = p ^ {g_lvl[3][6:0], cin};
    assign cy  = g_lvl[3][7];

endmodule

module fma_byte_serial_acc #(
    parameter int ACC_BYTES  = 3,   // legal 2..8
    parameter int PROD_BYTES = 2    // must not exceed ACC_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*PROD_BYTES-1:0] prod,
    input  logic                    clr_acc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*ACC_BYTES-1:0]  acc_out,
    output logic                    ovf
);

    localparam int ACC_W = 8 * ACC_BYTES;
    localparam int IDX_W = $clog2(ACC_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACC_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   op_r;
    logic               carry_r;
    logic               clr_r;
    logic [IDX_W-1:0]   byte_idx;
    logic               ovf_r;
    logic               out_valid_r;

    logic [IDX_W+2:0]   bit_base;
    logic [7:0]         slice_a;
    logic [7:0]         slice_b;
    logic [7:0]         slice_sum;
    logic               slice_cy;

    assign bit_base = {byte_idx, 3'b000};
    assign slice_a  = clr_r ? 8'h00 : acc[bit_base +: 8];
    assign slice_b  = op_r[bit_base +: 8];

    ksa_8 u_ksa (
        .a   (slice_a),
        .b   (slice_b),
        .cin (carry_r),
        .sum (slice_sum),
        .cy  (slice_cy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            op_r        <= '0;
            carry_r     <= 1'b0;
            clr_r       <= 1'b0;
            byte_idx    <= '0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= ACC_W'(prod);
                        clr_r    <= clr_acc;
                        carry_r  <= 1'b0;
                        byte_idx <= '0;
                        if (clr_acc) begin
                            ovf_r <= 1'b0;
                        end
                        state <= ADD;
                    end
                end
                ADD: begin
                    acc[bit_base +: 8] <= slice_sum;
                    carry_r            <= slice_cy;
                    byte_idx           <= byte_idx + 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        ovf_r <= ovf_r | slice_cy;
`ifdef FMA_ACC_SAT_EN
                        // Overrides the byte write above: clamp to all-ones.
                        if (slice_cy) begin
                            acc <= '1;
                        end
`endif
                        byte_idx    <= '0;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign acc_out   = acc;
    assign ovf       = ovf_r;

endmodule

`default_nettype wire

// File: tb/tb_fma_byte_serial_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fma_byte_serial_acc
// Purpose  : Directed bench with an arithmetic reference model for the
//            byte-serial accumulator (honours FMA_ACC_SAT_EN).
// Revision : 1.0 - initial release
// ============================================================================

module tb_fma_byte_serial_acc;

    localparam int ACC_BYTES  = 3;
    localparam int PROD_BYTES = 2;
    localparam int AW = 8 * ACC_BYTES;
    localparam int PW = 8 * PROD_BYTES;
`ifdef FMA_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] prod;
    logic          clr_acc;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] acc_out;
    logic          ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;

    always #5 clk = ~clk;

    fma_byte_serial_acc #(
        .ACC_BYTES  (ACC_BYTES),
        .PROD_BYTES (PROD_BYTES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .clr_acc   (clr_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction accepted in idle becomes visible
    // ACC_BYTES edges later as the modular (or saturated) sum.
    logic [AW-1:0] m_acc, p_acc;
    logic [AW:0]   m_sum;
    logic          m_ovf, p_ovf, m_done;
    int            m_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc  = '0;
            m_ovf  = 1'b0;
            m_done = 1'b0;
            m_cnt  = 0;
        end else if (m_done) begin
            if (out_ready) m_done = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_done = 1'b1;
                m_acc  = p_acc;
                m_ovf  = p_ovf;
            end
        end else if (in_valid) begin
            m_sum = (AW+1)'(clr_acc ? {AW{1'b0}} : m_acc) + (AW+1)'(prod);
            p_ovf = (clr_acc ? 1'b0 : m_ovf) | m_sum[AW];
            p_acc = (SAT && m_sum[AW]) ? {AW{1'b1}} : m_sum[AW-1:0];
            m_cnt = ACC_BYTES;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("in_ready", in_ready, (m_cnt == 0 && !m_done));
            chk("out_valid", out_valid, m_done);
            if (m_cnt == 0) begin
                chk("acc_out", acc_out, m_acc);
                chk("ovf", ovf, m_ovf);
            end
        end
    end

    task automatic do_pass(input logic [PW-1:0] p, input logic c, output int latency);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        prod     = p;
        clr_acc  = c;
        for (n = 1; n <= 50; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            clr_acc  = 1'b0;
            if (out_valid) break;
        end
        latency = n;
        if (n > 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pass_timeout: out_valid never rose for prod 0x%0h", p);
        end
    endtask

    task automatic fill_ffff00();
        int l;
        do_pass(16'hFFFF, 1'b1, l);
        for (int i = 0; i < 255; i++) do_pass(16'hFFFF, 1'b0, l);
        chk("fill_acc", acc_out, 24'hFFFF00);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        prod      = '0;
        clr_acc   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_acc", acc_out, 24'h000000);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Clear pass and latency
        do_pass(16'h1234, 1'b1, lat);
        chk("clr_acc_val", acc_out, 24'h001234);
        chk("clr_ovf", ovf, 1'b0);
        chk("clr_latency", lat, 4);
        chk("clr_busy", in_ready, 1'b0);
        @(negedge clk);
        chk("clr_ready_back", in_ready, 1'b1);

        // Carry ripple through every byte
        do_pass(16'hFFFF, 1'b1, lat);
        chk("ripple_pre", acc_out, 24'h00FFFF);
        do_pass(16'h0001, 1'b0, lat);
        chk("ripple_acc", acc_out, 24'h010000);
        chk("ripple_ovf", ovf, 1'b0);

        // Overflow, stickiness, then clear
        fill_ffff00();
        do_pass(16'h0100, 1'b0, lat);
        chk("ovf_acc", acc_out, SAT ? 24'hFFFFFF : 24'h000000);
        chk("ovf_flag", ovf, 1'b1);
        do_pass(16'h0003, 1'b0, lat);
        chk("sticky_acc", acc_out, SAT ? 24'hFFFFFF : 24'h000003);
        chk("sticky_ovf", ovf, 1'b1);
        do_pass(16'h0005, 1'b1, lat);
        chk("clear_acc", acc_out, 24'h000005);
        chk("clear_ovf", ovf, 1'b0);

        // Backpressure in DONE with ignored input pulses
        @(negedge clk);
        out_ready = 1'b0;
        do_pass(16'h0010, 1'b0, lat);
        chk("bp_acc", acc_out, 24'h000015);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = (k % 2 == 0);
            prod     = 16'hAAAA;
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", in_ready, 1'b0);
            chk("bp_hold_acc", acc_out, 24'h000015);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", in_ready, 1'b1);
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_acc", acc_out, 24'h000015);

        // Asynchronous reset mid-cycle while holding an overflowed result
        fill_ffff00();
        @(negedge clk);
        out_ready = 1'b0;
        do_pass(16'h0100, 1'b0, lat);
        chk("pre_rst_ovf", ovf, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_acc", acc_out, 24'h000000);
        chk("async_rst_ovf", ovf, 1'b0);
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;

        // Reset during ADD byte 1
        @(negedge clk);
        in_valid = 1'b1;
        prod     = 16'h1234;
        clr_acc  = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_add_partial", acc_out, 24'h000034);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_acc", acc_out, 24'h000000);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        do_pass(16'h0042, 1'b1, lat);
        chk("after_rst_acc", acc_out, 24'h000042);
        chk("after_rst_ovf", ovf, 1'b0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
